// File: rtl/soglia_pkg.sv
// rtl/soglia_pkg.sv - shared types and helpers for the multi-channel threshold alarm
package soglia_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      ALARM   = 2'd2,
      ACKED   = 2'd3
   } ch_state_t;

   // An acknowledge arriving with a release sample takes the ACKED path so the clear pulse is not lost.
   localparam bit ACK_OVER_RELEASE = 1'b1;

   function automatic int cnt_width(input int persist);
      return (persist < 1) ? 1 : $clog2(persist + 1);
   endfunction

endpackage

// File: rtl/soglia_multi_alarm_if.sv
// rtl/soglia_multi_alarm_if.sv - level/threshold inputs, acknowledge and alarm outputs bundle
interface soglia_multi_alarm_if #(
   parameter int NCH  = 4,
   parameter int MAXB = 9
);
   logic                  sw;
   logic [NCH-1:0]        ch_en;
   logic [NCH-1:0]        dir;
   logic                  sample_valid;
   logic [NCH*MAXB-1:0]   livello;
   logic [NCH*MAXB-1:0]   soglia;
   logic                  change;
   logic                  enchange_al;
   logic [NCH-1:0]        alarm;
   logic [NCH-1:0]        clear;
   logic                  alarm_any;

   modport master (
      output sw, ch_en, dir, sample_valid, livello, soglia, change, enchange_al,
      input  alarm, clear, alarm_any
   );

   modport slave (
      input  sw, ch_en, dir, sample_valid, livello, soglia, change, enchange_al,
      output alarm, clear, alarm_any
   );
endinterface

// File: rtl/soglia_ch.sv
// rtl/soglia_ch.sv - one channel: compare, persistence counter, hysteresis release, ack FSM
module soglia_ch
   import soglia_pkg::*;
#(
   parameter int MAXB    = 9,
   parameter int PERSIST = 3,
   parameter int HYST    = 8,
   parameter int LATCH   = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            active,
   input  logic            dir,
   input  logic            valid,
   input  logic            ack,
   input  logic [MAXB-1:0] livello,
   input  logic [MAXB-1:0] soglia,
   output logic            alarm,
   output logic            clear
);
   localparam int              CW       = cnt_width(PERSIST);
   localparam logic [CW-1:0]   CNT_LAST = CW'(PERSIST - 1);
   localparam logic [MAXB:0]   HYST_X   = (MAXB+1)'(HYST);
   localparam logic [MAXB:0]   TOP_X    = {1'b0, {MAXB{1'b1}}};

   ch_state_t     state;
   logic [CW-1:0] cnt;
   logic [MAXB:0] lv_x, th_x;
   logic          trip, rel, rel_go;

   assign lv_x = {1'b0, livello};
   assign th_x = {1'b0, soglia};
   assign trip = dir ? (livello >= soglia) : (livello <= soglia);

   // Bands that would wrap past 0 or past full scale disable release entirely.
   assign rel    = dir ? ((th_x >= HYST_X) && (lv_x < th_x - HYST_X))
                       : ((th_x + HYST_X <= TOP_X) && (lv_x > th_x + HYST_X));
   assign rel_go = (LATCH == 0) && valid && rel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         alarm <= 1'b0;
         clear <= 1'b0;
      end else if (!active) begin
         state <= IDLE;
         cnt   <= '0;
         alarm <= 1'b0;
         clear <= 1'b0;
      end else begin
         clear <= 1'b0;
         case (state)
            IDLE: begin
               if (valid && trip) begin
                  cnt <= CW'(1);
                  if (PERSIST <= 1) begin
                     state <= ALARM;
                     alarm <= 1'b1;
                  end else begin
                     state <= PENDING;
                  end
               end
            end
            PENDING: begin
               if (valid && trip) begin
                  cnt <= cnt + CW'(1);
                  if (cnt >= CNT_LAST) begin
                     state <= ALARM;
                     alarm <= 1'b1;
                  end
               end else if (valid) begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            ALARM: begin
               if (ack && (ACK_OVER_RELEASE || !rel_go)) begin
                  state <= ACKED;
                  alarm <= 1'b0;
                  clear <= 1'b1;
               end else if (rel_go) begin
                  state <= IDLE;
                  alarm <= 1'b0;
                  cnt   <= '0;
               end
            end
            ACKED: begin
               if (valid && rel) begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               alarm <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: rtl/soglia_multi_alarm.sv
// rtl/soglia_multi_alarm.sv - NCH-channel threshold alarm with shared acknowledge
module soglia_multi_alarm
   import soglia_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int MAXB    = 9,
   parameter int PERSIST = 3,
   parameter int HYST    = 8,
   parameter int LATCH   = 1
) (
   input  logic clk,
   input  logic rst_n,
   soglia_multi_alarm_if.slave bus
);
   logic           ack;
   logic [NCH-1:0] alarm_w;
   logic [NCH-1:0] clear_w;

   assign ack = bus.change & bus.enchange_al;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      soglia_ch #(
         .MAXB    (MAXB),
         .PERSIST (PERSIST),
         .HYST    (HYST),
         .LATCH   (LATCH)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .active  (bus.sw & bus.ch_en[i]),
         .dir     (bus.dir[i]),
         .valid   (bus.sample_valid),
         .ack     (ack),
         .livello (bus.livello[i*MAXB +: MAXB]),
         .soglia  (bus.soglia[i*MAXB +: MAXB]),
         .alarm   (alarm_w[i]),
         .clear   (clear_w[i])
      );
   end

   assign bus.alarm     = alarm_w;
   assign bus.clear     = clear_w;
   assign bus.alarm_any = |alarm_w;
endmodule
